// File: rtl/outport_pulse.sv
// ============================================================================
// Module   : outport_pulse
// Brief    : Addressed output port with per-bit level/pulse modes and a
//            sticky pulse-complete interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module outport_pulse #(
  parameter logic [7:0] ADDR      = 8'h04,
  parameter int         WIDTH     = 8,
  parameter int         PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wen,
  input  logic [WIDTH-1:0] pulse_conf,
  output logic [WIDTH-1:0] port_out,
  output logic             busy,
  output logic             int_out,
  input  logic             int_ack
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  localparam logic [7:0] C_LOAD = 8'(PULSE_LEN - 1);

  state_t           r_state;
  logic [7:0]       r_count;
  logic [WIDTH-1:0] r_pmask;
  logic [WIDTH-1:0] r_port;
  logic             r_busy;
  logic             r_int;

  logic             w_accept;
  logic             w_pulse_req;
  logic             w_done;
  logic [WIDTH-1:0] w_lvl;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_port_pulse;

  assign w_accept    = wen && (address == ADDR);
  assign w_pulse_req = |(data_in & pulse_conf);
  assign w_done      = (r_state == PULSE) && (r_count == 8'd0);

  // While pulsing, only bits that are level now and not part of the running
  // pulse may follow a write; the running pulse bits clear on the last cycle.
  assign w_lvl        = w_accept ? (~pulse_conf & ~r_pmask) : '0;
  assign w_clr        = w_done ? r_pmask : '0;
  assign w_port_pulse = ((r_port & ~w_lvl) | (data_in & w_lvl)) & ~w_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= 8'd0;
      r_pmask <= '0;
      r_port  <= '0;
      r_busy  <= 1'b0;
      r_int   <= 1'b0;
    end else begin
      if (w_done) begin
        r_int <= 1'b1;
      end else if (int_ack) begin
        r_int <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_port <= data_in;
            if (w_pulse_req) begin
              r_pmask <= pulse_conf;
              r_count <= C_LOAD;
              r_state <= PULSE;
              r_busy  <= 1'b1;
            end
          end
        end
        PULSE: begin
          r_port <= w_port_pulse;
          if (r_count == 8'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign port_out = r_port;
  assign busy     = r_busy;
  assign int_out  = r_int;

endmodule

`default_nettype wire

// File: doc/outport_pulse.md
OUTPORT_PULSE -- requirements
Module: outport_pulse

Interface
REQ-001 The block SHALL have parameter ADDR, default 8'h04, meaning the port address decoded for writes.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the port width in bits (1..8).
REQ-003 The block SHALL have parameter PULSE_LEN, default 4, meaning the pulse duration in clk cycles (1..255).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; one clock, reset asynchronous and active-low (asserted when 0).
REQ-006 address  input  8  processor port address.
REQ-007 data_in  input  WIDTH  processor write data.
REQ-008 wen  input  1  write strobe, one cycle per write.
REQ-009 pulse_conf  input  WIDTH  per-bit mode: 1 = pulse bit, 0 = level bit.
REQ-010 port_out  output  WIDTH  registered output pins.
REQ-011 busy  output  1  high while a pulse is in progress.
REQ-012 int_out  output  1  sticky pulse-complete interrupt.
REQ-013 int_ack  input  1  interrupt acknowledge, clears int_out.

Function
REQ-014 A write SHALL be accepted on a rising clk edge only when wen=1 and address==ADDR; any other address or wen=0 SHALL leave all state unchanged.
REQ-015 On an accepted write, level bits (pulse_conf[i]=0) SHALL take data_in[i] at that edge and hold until the next accepted write.
REQ-016 The FSM SHALL have two states: IDLE and PULSE; busy SHALL be 1 exactly when state is PULSE.
REQ-017 On an accepted write in IDLE with (data_in & pulse_conf) != 0: pulse bits SHALL take data_in at that edge, pmask SHALL latch pulse_conf, counter SHALL load PULSE_LEN-1, state SHALL go to PULSE.
REQ-018 On an accepted write in IDLE with (data_in & pulse_conf) == 0: only level bits SHALL update; pulse bits SHALL stay 0; no PULSE entry; no interrupt.
REQ-019 In PULSE with counter != 0, counter SHALL decrement by 1 per cycle.
REQ-020 In PULSE with counter == 0, port_out bits in pmask SHALL clear to 0, state SHALL return to IDLE, and int_out SHALL be set, all at the same edge.
REQ-021 Pulse bits SHALL therefore be high for exactly PULSE_LEN cycles; PULSE_LEN=1 SHALL give a one-cycle pulse.
REQ-022 Changes to pulse_conf during PULSE SHALL not affect the pulse in progress; pmask governs the clear.
REQ-023 An accepted write during PULSE SHALL update level bits (per current pulse_conf, excluding pmask bits) immediately; pulse data SHALL be ignored (no retrigger, counter unaffected).
REQ-024 An accepted write in the same cycle as pulse completion SHALL be treated as during PULSE (ignored for pulse bits).
REQ-025 int_out SHALL remain 1 until a cycle with int_ack=1 clears it; if set and int_ack coincide, set SHALL win.
REQ-026 All outputs SHALL be driven directly from registers.

Reset
REQ-027 While rst=0, port_out=0, busy=0, int_out=0, state=IDLE, counter=0, pmask=0, asynchronously.
REQ-028 Reset asserted mid-pulse SHALL abort the pulse with no interrupt; after release the block SHALL accept writes from the first rising edge.

Verification
REQ-029 Defaults, pulse_conf=8'h0F: write 8'hA5 to 8'h04 -> port_out=8'hA5 next edge, busy=1, low nibble clears after exactly 4 cycles (port_out=8'hA0), int_out=1, busy=0.
REQ-030 Write 8'hF0 to 8'h04, pulse_conf=8'h0F -> port_out=8'hF0, busy stays 0, int_out stays 0.
REQ-031 Write 8'hFF to 8'h10 -> port_out unchanged, no busy, no interrupt.
REQ-032 During a pulse of 8'h03, write 8'h5C -> high nibble becomes 8'h50 at once, low bits keep 2'b11 until original end, counter not restarted.
REQ-033 int_out=1, int_ack pulsed one cycle -> int_out=0 next edge; completion coinciding with int_ack -> int_out=1.
REQ-034 rst=0 two cycles into a pulse -> port_out=0, busy=0, int_out=0 immediately; no interrupt after release.
